muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer that produces HI/LO results for MULT, MULTU, DIV and DIVU.
- Sits beside the ALU in EX and drives the HI/LO register write port.
- Stalls the pipeline until the result is ready.
- Division is iterative radix-2 restoring; multiply is single-shot by default.
- Accepts pipeline flush to cancel an in-flight operation.

---
 rtl/muldiv_ctrl.sv | 156 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer driving the HI/LO write port
// Define MULDIV_ITER_MUL_EN for a 32-cycle shift-add multiply instead of the single-cycle one.
module muldiv_ctrl #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        hilo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div0
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
    localparam logic [4:0] LAST = 5'(DIV_ITERS - 1);

    state_t      state, state_next;
    logic        sign_a, sign_b;
    logic [31:0] rem, quo, mag_b;
    logic [4:0]  cnt;
    logic        is_signed;
    logic [31:0] abs_a, abs_b;
    logic [32:0] trial;
    logic [63:0] prod_raw, product;

    assign is_signed = ~op[0];
    assign abs_a     = (is_signed && a[31]) ? -a : a;
    assign abs_b     = (is_signed && b[31]) ? -b : b;
    assign trial     = {rem, quo[31]} - {1'b0, mag_b};

`ifdef MULDIV_ITER_MUL_EN
    logic        is_div;
    logic [32:0] mul_sum;
    assign mul_sum  = {1'b0, rem} + (quo[0] ? {1'b0, mag_b} : 33'd0);
    assign prod_raw = {rem, quo};
`else
    assign prod_raw = {32'd0, quo} * {32'd0, mag_b};
`endif
    // Sign flags are only ever set for signed ops, so MULTU/DIVU pass straight through.
    assign product = (sign_a ^ sign_b) ? -prod_raw : prod_raw;

    assign stall = (state == S_IDLE && start && !flush) || (state == S_MUL) ||
                   (state == S_DIV) || (state == S_FIX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) begin
                if (!op[1])         state_next = S_MUL;
                else if (b == '0)   state_next = S_DONE;
                else                state_next = S_DIV;
            end
`ifdef MULDIV_ITER_MUL_EN
            S_MUL:  if (cnt == LAST) state_next = S_FIX;
`else
            S_MUL:  state_next = S_DONE;
`endif
            S_DIV:  if (cnt == LAST) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flush) state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            rem     <= '0;
            quo     <= '0;
            mag_b   <= '0;
            cnt     <= '0;
            hilo_we <= 1'b0;
            div0    <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
`ifdef MULDIV_ITER_MUL_EN
            is_div  <= 1'b0;
`endif
        end else begin
            hilo_we <= 1'b0;
            div0    <= 1'b0;
            if (!flush) begin
                case (state)
                    S_IDLE: if (start) begin
                        sign_a <= is_signed & a[31];
                        sign_b <= is_signed & b[31];
                        rem    <= '0;
                        quo    <= abs_a;
                        mag_b  <= abs_b;
                        cnt    <= '0;
`ifdef MULDIV_ITER_MUL_EN
                        is_div <= op[1];
`endif
                        if (op[1] && b == '0) begin
                            hi_o    <= a;
                            lo_o    <= '1;
                            hilo_we <= 1'b1;
                            div0    <= 1'b1;
                        end
                    end
`ifdef MULDIV_ITER_MUL_EN
                    S_MUL: begin
                        rem <= mul_sum[32:1];
                        quo <= {mul_sum[0], quo[31:1]};
                        cnt <= cnt + 5'd1;
                    end
`else
                    S_MUL: begin
                        hi_o    <= product[63:32];
                        lo_o    <= product[31:0];
                        hilo_we <= 1'b1;
                    end
`endif
                    S_DIV: begin
                        if (!trial[32]) begin
                            rem <= trial[31:0];
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= {rem[30:0], quo[31]};
                            quo <= {quo[30:0], 1'b0};
                        end
                        cnt <= cnt + 5'd1;
                    end
                    S_FIX: begin
`ifdef MULDIV_ITER_MUL_EN
                        if (!is_div) begin
                            hi_o <= product[63:32];
                            lo_o <= product[31:0];
                        end else begin
                            lo_o <= (sign_a ^ sign_b) ? -quo : quo;
                            hi_o <= sign_a ? -rem : rem;
                        end
`else
                        lo_o <= (sign_a ^ sign_b) ? -quo : quo;
                        hi_o <= sign_a ? -rem : rem;
`endif
                        hilo_we <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - randomized and directed self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;
`ifdef MULDIV_ITER_MUL_EN
    localparam int MUL_LAT = 34;
`else
    localparam int MUL_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        stall, hilo_we, div0;
    logic [31:0] hi_o, lo_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Pending operation as seen by the model: expected timing window and result.
    logic        p_valid = 1'b0;
    logic        p_we = 1'b0;
    logic        p_div0 = 1'b0;
    logic [31:0] p_hi = '0, p_lo = '0;
    int          p_start = 0, p_end = 0, p_we_cyc = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    muldiv_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .stall(stall), .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o), .div0(div0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el,
                                  output logic ed, output int lat);
        longint sx, sy, q, r;
        logic [63:0] p, qv, rv;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ed = 1'b0;
        lat = MUL_LAT;
        case (o)
            2'b00:   p = 64'(sx * sy);
            2'b01:   p = {32'd0, x} * {32'd0, y};
            default: p = '0;
        endcase
        eh = p[63:32];
        el = p[31:0];
        if (o[1]) begin
            lat = 34;
            if (y == 0) begin
                eh = x; el = '1; ed = 1'b1; lat = 1;
            end else if (o == 2'b10) begin
                q = sx / sy; r = sx % sy;
                qv = 64'(q); rv = 64'(r);
                el = qv[31:0]; eh = rv[31:0];
            end else begin
                el = x / y; eh = x % y;
            end
        end
    endfunction

    always @(negedge clk) begin
        logic e_we, e_st;
        if (!rst) begin
            m_hi = '0;
            m_lo = '0;
        end
        e_we = rst && p_valid && p_we && (cyc == p_we_cyc);
        e_st = rst && p_valid && (cyc >= p_start) && (cyc < p_end);
        if (e_we) begin
            m_hi = p_hi;
            m_lo = p_lo;
        end
        chk("stall", stall, e_st);
        chk("hilo_we", hilo_we, e_we);
        chk("div0", div0, e_we && p_div0);
        chk("hi_o", hi_o, m_hi);
        chk("lo_o", lo_o, m_lo);
    end

    task automatic begin_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                            output int lat);
        logic [31:0] eh, el;
        logic ed;
        model(o, x, y, eh, el, ed, lat);
        @(posedge clk); #1;
        p_hi = eh; p_lo = el; p_div0 = ed;
        p_start = cyc; p_we_cyc = cyc + lat; p_end = cyc + lat;
        p_we = 1'b1; p_valid = 1'b1;
        start = 1'b1; op = o; a = x; b = y; flush = 1'b0;
    endtask

    // fk: cycle offset from start at which flush is raised, -1 for none.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int fk);
        int lat;
        begin_op(o, x, y, lat);
        if (fk == 0) begin
            flush = 1'b1; p_we = 1'b0; p_end = cyc;
        end else begin
            for (int k = 1; k <= lat; k++) begin
                @(posedge clk); #1;
                if (k == fk) begin
                    flush = 1'b1; p_we = 1'b0; p_end = cyc + 1;
                    break;
                end
            end
        end
        if (fk >= 0) begin
            @(posedge clk); #1;
            flush = 1'b0; start = 1'b0;
        end
    endtask

    task automatic check_res(input string name, input logic [31:0] eh, input logic [31:0] el,
                             input logic ed);
        chk({name, "_we"}, hilo_we, 1'b1);
        chk({name, "_div0"}, div0, ed);
        chk({name, "_hi"}, hi_o, eh);
        chk({name, "_lo"}, lo_o, el);
        chk({name, "_model_hi"}, p_hi, eh);
        chk({name, "_model_lo"}, p_lo, el);
    endtask

    initial begin
        int lat;
        logic [1:0] o;
        logic [31:0] x, y, dh, dl;
        logic dd;
        int fk;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_hi", hi_o, 32'h0);
        chk("reset_lo", lo_o, 32'h0);
        chk("reset_we", hilo_we, 1'b0);
        chk("reset_stall", stall, 1'b0);
        rst = 1'b1;

        do_op(2'b01, 32'hFFFF_FFFF, 32'h2, -1);
        check_res("multu", 32'h1, 32'hFFFF_FFFE, 1'b0);
        do_op(2'b00, 32'hFFFF_FFFD, 32'h5, -1);
        check_res("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'h2, -1);
        check_res("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        do_op(2'b11, 32'h64, 32'h0, -1);
        check_res("divu0", 32'h64, 32'hFFFF_FFFF, 1'b1);
        do_op(2'b11, 32'h64, 32'h7, 10);
        chk("flush_hi", hi_o, 32'h64);
        chk("flush_lo", lo_o, 32'hFFFF_FFFF);
        chk("flush_we", hilo_we, 1'b0);
        do_op(2'b11, 32'h64, 32'h7, -1);
        check_res("divu", 32'h2, 32'hE, 1'b0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        check_res("div_ovf", 32'h0, 32'h8000_0000, 1'b0);

        begin_op(2'b10, 32'h1234_5678, 32'h3, lat);
        repeat (5) begin @(posedge clk); #1; end
        #2;
        rst = 1'b0; start = 1'b0; p_valid = 1'b0;
        #1;
        chk("async_rst_hi", hi_o, 32'h0);
        chk("async_rst_lo", lo_o, 32'h0);
        chk("async_rst_we", hilo_we, 1'b0);
        chk("async_rst_stall", stall, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        do_op(2'b01, 32'h3, 32'h4, -1);
        check_res("multu_after_rst", 32'h0, 32'hC, 1'b0);

        for (int i = 0; i < 80; i++) begin
            o = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: begin x = $urandom; y = 32'h0; end
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: begin x = 32'($urandom_range(0, 200)); y = 32'($urandom_range(1, 15)); end
                3: begin x = -32'($urandom_range(0, 200)); y = 32'($urandom_range(1, 15)); end
                default: begin x = $urandom; y = $urandom; end
            endcase
            model(o, x, y, dh, dl, dd, lat);
            fk = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, lat - 1)) : -1;
            do_op(o, x, y, fk);
        end

        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
